dp_done_sync: RTL
=================

# dp_done_sync

Parametrised start-dispatch and done-aggregation controller for N_DP datapath channels. It sits between the HWPE peripheral slave and the per-datapath FSMs. It fans one slave start pulse out to an enable-masked set of channels and merges their done pulses into one done pulse, in either all-done or any-done mode. It adds a programmable watchdog timeout, an immediate completion for an empty mask, and sticky protocol-error reporting.

## Interface
- N_DP, 2, number of datapath channels (1..32)
- TIMEOUT_W, 16, watchdog counter/threshold width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous clear (slave clear_o), highest priority after reset
- start_i  in  1  single-cycle start pulse from slave
- enable_mask_i  in  N_DP  channel enable mask, sampled with start_i
- mode_i  in  1  0 = ALL (all enabled channels done), 1 = ANY (first enabled channel done); sampled with start_i
- timeout_i  in  TIMEOUT_W  watchdog limit in RUN cycles, 0 = disabled; sampled with start_i
- dp_done_i  in  N_DP  per-channel single-cycle done pulses
- dp_start_o  out  N_DP  per-channel single-cycle start pulses
- done_o  out  1  single-cycle aggregate done pulse (to slave ctrl.done)
- timeout_o  out  1  single-cycle pulse, coincident with done_o when the job ended by watchdog
- busy_o  out  1  high while in RUN
- done_mask_o  out  N_DP  per-channel done levels of the current or last job
- err_o  out  1  sticky protocol-error flag

## Operation
- State machine: IDLE, RUN.
- Snapshot registers: active_q[N_DP], mode_q, tmo_q. They are loaded on an accepted start and held until the next accepted start.
- IDLE, start_i=1, enable_mask_i≠0:
  - load the snapshots and clear done_mask_o and the counter;
  - dp_start_o=enable_mask_i in the next cycle;
  - go to RUN.
- IDLE, start_i=1, enable_mask_i=0:
  - done_o pulses in the next cycle;
  - no dp_start_o;
  - active_q=0, done_mask_o=0;
  - stay in IDLE.
- RUN, each cycle:
  - lvl_next = done_mask_o | (dp_done_i & active_q);
  - complete = (mode_q=0 ? (lvl_next & active_q)==active_q : lvl_next≠0).
- Complete → done_o pulses next cycle, go to IDLE, done_mask_o=lvl_next.
- Watchdog:
  - the counter is 0 in the first RUN cycle and increments every RUN cycle;
  - if tmo_q≠0, count==tmo_q-1 and not complete → done_o and timeout_o pulse next cycle, go to IDLE;
  - done_mask_o keeps the partial levels.
- Complete and timeout in the same cycle → completion wins, timeout_o stays 0.
- IDLE after ANY-mode completion or a timeout: dp_done_i[k] with active_q[k]=1 and done_mask_o[k]=0 sets done_mask_o[k]. It is a late finisher, not an error.
- err_o set (sticky) on any of:
  - dp_done_i[k] with active_q[k]=0;
  - dp_done_i[k] with done_mask_o[k] already 1;
  - start_i while in RUN; the start is ignored.
- err_o is cleared only by clear_i or rst_i.
- clear_i: next cycle state=IDLE; all snapshots, the counter, done_mask_o and err_o are 0; no pulse outputs. A start_i in the same cycle is ignored.
- Counter saturates at all-ones (no wrap) when tmo_q=0.

## Timing
- Reset: every output 0, state IDLE, all snapshots 0.
- All outputs are registered; there is no combinational input→output path.
- Start latency: start_i at cycle T → dp_start_o and busy_o high from T+1. dp_start_o lasts one cycle.
- Done latency: completing dp_done_i at cycle T → done_o at T+1, busy_o low at T+1.
- Timeout latency: start at T with tmo_q=K → RUN covers T+1..T+K, done_o and timeout_o at T+K+1.
- A new start_i is accepted in the same cycle that done_o is high (state is already IDLE).
- Reset asserted mid-RUN: outputs drop asynchronously; no done_o is produced after release.

## Test plan
- N_DP=2, ALL mode, mask=2'b11, start at T. dp_done_i[0] at T+5, dp_done_i[1] at T+9 → dp_start_o=11 at T+1, done_o at T+10 only, done_mask_o=11, err_o=0.
- ANY mode, mask=2'b11. dp_done_i[1] at T+4, dp_done_i[0] at T+7 → done_o at T+5, done_mask_o=10 at T+5 and 11 at T+8, err_o=0.
- Mask=0, start at T → done_o at T+1, dp_start_o never high, busy_o never high.
- ALL mode, mask=2'b01, timeout_i=8, no done → done_o and timeout_o at T+9. Repeat with dp_done_i[0] at T+8 → done_o at T+9, timeout_o=0.
- mask=2'b01: dp_done_i[1] during RUN, then start_i during RUN → err_o set and held, job unaffected. Then clear_i → err_o=0, state IDLE.
- N_DP=4, mask=4'b1010, rst_i pulse at T+3 → all outputs 0 immediately. A fresh start afterwards behaves normally with no stale done_mask_o.

Source files
------------

// File: rtl/dp_done_sync.sv
// rtl/dp_done_sync.sv - start fan-out and done aggregation for N_DP datapath channels
// Adds a watchdog timeout, empty-mask completion and sticky protocol-error reporting.
module dp_done_sync #(
  parameter int unsigned N_DP      = 2,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [N_DP-1:0]      enable_mask_i,
  input  logic                 mode_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [N_DP-1:0]      dp_done_i,
  output logic [N_DP-1:0]      dp_start_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic                 busy_o,
  output logic [N_DP-1:0]      done_mask_o,
  output logic                 err_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q;
  logic [N_DP-1:0]      active_q;
  logic                 mode_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] cnt_q;

  logic [N_DP-1:0]      lvl_next;
  logic                 complete;
  logic                 tmo_hit;
  logic                 proto_err;
  logic [TIMEOUT_W-1:0] cnt_next;

  always_comb begin
    lvl_next  = done_mask_o | (dp_done_i & active_q);
    complete  = mode_q ? (lvl_next != '0) : ((lvl_next & active_q) == active_q);
    tmo_hit   = (tmo_q != '0) && (cnt_q == tmo_q - TIMEOUT_W'(1));
    proto_err = (|(dp_done_i & ~active_q)) || (|(dp_done_i & done_mask_o)) ||
                (start_i && (state_q == RUN));
    // Saturate so a disabled watchdog never wraps back to a matching value.
    cnt_next  = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
  end

  assign busy_o = (state_q == RUN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      active_q    <= '0;
      mode_q      <= 1'b0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      done_mask_o <= '0;
      dp_start_o  <= '0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_o       <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      active_q    <= '0;
      mode_q      <= 1'b0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      done_mask_o <= '0;
      dp_start_o  <= '0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      dp_start_o <= '0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
      if (proto_err) err_o <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            active_q    <= enable_mask_i;
            mode_q      <= mode_i;
            tmo_q       <= timeout_i;
            cnt_q       <= '0;
            done_mask_o <= '0;
            if (enable_mask_i != '0) begin
              dp_start_o <= enable_mask_i;
              state_q    <= RUN;
            end else begin
              done_o <= 1'b1;
            end
          end else begin
            // Late finishers after an ANY completion or a timeout still record their level.
            done_mask_o <= lvl_next;
          end
        end
        RUN: begin
          done_mask_o <= lvl_next;
          if (complete) begin
            done_o  <= 1'b1;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
